// File: rtl/hermes_local_injector.sv
// Hermes LOCAL-port packet source: header, size and memory-streamed payload flits over a credit link.
// Define HERMES_INJECTOR_CHECKSUM_EN to append an XOR trailer flit (size flit then carries len+1).
module hermes_local_injector #(
   parameter int FLIT_WIDTH       = 32,
   parameter int MEMORY_BUS_WIDTH = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int SIZE_WIDTH       = 16,
   parameter int PREFETCH_DEPTH   = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start_i,
   input  logic [15:0]                 dest_i,
   input  logic [ADDR_WIDTH-1:0]       base_i,
   input  logic [SIZE_WIDTH-1:0]       len_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        mem_en_o,
   output logic [ADDR_WIDTH-1:0]       mem_addr_o,
   input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_i,
   output logic [FLIT_WIDTH-1:0]       data_o,
   output logic                        tx,
   input  logic                        credit_i,
   output logic                        clock_tx
);

   localparam int PW = $clog2(PREFETCH_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_SIZE    = 3'd2,
      S_PAYLOAD = 3'd3,
`ifdef HERMES_INJECTOR_CHECKSUM_EN
      S_TRAILER = 3'd4,
`endif
      S_DONE    = 3'd5
   } state_t;

`ifdef HERMES_INJECTOR_CHECKSUM_EN
   localparam state_t S_TAIL = S_TRAILER;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t                      state_q, state_nxt;
   logic [15:0]                 dest_q;
   logic [ADDR_WIDTH-1:0]       base_q;
   logic [SIZE_WIDTH-1:0]       len_q, issued_q, remain_q;
   logic [MEMORY_BUS_WIDTH-1:0] fifo_mem [PREFETCH_DEPTH];
   logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]               cnt_q;
   logic [CW:0]                 occ_next;
   logic                        vld_p1;
   logic [MEMORY_BUS_WIDTH-1:0] head;
   logic [FLIT_WIDTH-1:0]       size_flit;
   logic                        fire, pop, accept, fetch_state;
`ifdef HERMES_INJECTOR_CHECKSUM_EN
   logic [MEMORY_BUS_WIDTH-1:0] xor_q;
`endif

   assign clock_tx = clock;
   assign head     = fifo_mem[rd_ptr_q];
   assign fire     = tx & credit_i;
   assign pop      = (state_q == S_PAYLOAD) & fire;
   assign accept   = (state_q == S_IDLE) & start_i;

`ifdef HERMES_INJECTOR_CHECKSUM_EN
   assign size_flit = FLIT_WIDTH'({1'b0, len_q} + {{SIZE_WIDTH{1'b0}}, 1'b1});
`else
   assign size_flit = FLIT_WIDTH'(len_q);
`endif

   // Occupancy after this edge counts the word landing now; a new read is safe only if its
   // data, arriving next cycle, still fits. Crediting the pop keeps 1 flit/cycle at depth 2.
   assign occ_next    = {1'b0, cnt_q} + (CW+1)'(vld_p1) - (CW+1)'(pop);
   assign fetch_state = (state_q == S_HEADER) | (state_q == S_SIZE) | (state_q == S_PAYLOAD);
   assign mem_en_o    = fetch_state & (issued_q < len_q) & (occ_next < (CW+1)'(PREFETCH_DEPTH));
   assign mem_addr_o  = base_q + ADDR_WIDTH'(issued_q);

   always_comb begin
      tx     = 1'b0;
      data_o = '0;
      case (state_q)
         S_HEADER: begin
            tx     = 1'b1;
            data_o = FLIT_WIDTH'(dest_q);
         end
         S_SIZE: begin
            tx     = 1'b1;
            data_o = size_flit;
         end
         S_PAYLOAD: begin
            tx     = (cnt_q != '0);
            data_o = FLIT_WIDTH'(head);
         end
`ifdef HERMES_INJECTOR_CHECKSUM_EN
         S_TRAILER: begin
            tx     = 1'b1;
            data_o = FLIT_WIDTH'(xor_q);
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:    if (start_i) state_nxt = S_HEADER;
         S_HEADER:  if (fire) state_nxt = S_SIZE;
         S_SIZE:    if (fire) state_nxt = (len_q != '0) ? S_PAYLOAD : S_TAIL;
         S_PAYLOAD: if (pop && remain_q == SIZE_WIDTH'(1)) state_nxt = S_TAIL;
`ifdef HERMES_INJECTOR_CHECKSUM_EN
         S_TRAILER: if (fire) state_nxt = S_DONE;
`endif
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         vld_p1   <= 1'b0;
         dest_q   <= '0;
         base_q   <= '0;
         len_q    <= '0;
         issued_q <= '0;
         remain_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_nxt;
         busy_o  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
         done_o  <= (state_nxt == S_DONE);
         // p1: read data returned by memory, pushed into the prefetch FIFO
         vld_p1  <= mem_en_o;
         if (mem_en_o) issued_q <= issued_q + SIZE_WIDTH'(1);
         if (vld_p1) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            remain_q <= remain_q - SIZE_WIDTH'(1);
         end
         cnt_q <= cnt_q + CW'(vld_p1) - CW'(pop);
         if (accept) begin
            dest_q   <= dest_i;
            base_q   <= base_i;
            len_q    <= len_i;
            issued_q <= '0;
            remain_q <= len_i;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (vld_p1) fifo_mem[wr_ptr_q] <= mem_data_i;
`ifdef HERMES_INJECTOR_CHECKSUM_EN
      if (accept) xor_q <= '0;
      else if (pop) xor_q <= xor_q ^ head;
`endif
   end

endmodule

// File: tb/tb_hermes_local_injector.sv
// Directed bench for hermes_local_injector: vector table of packets plus reset-mid-packet sequence.
module tb_hermes_local_injector;

   logic        clock = 1'b0;
   logic        reset, start_i, credit_i;
   logic [15:0] dest_i;
   logic [31:0] base_i;
   logic [15:0] len_i;
   logic        busy_o, done_o, mem_en_o, tx, clock_tx;
   logic [31:0] mem_addr_o, mem_data_i, data_o;

   hermes_local_injector dut (
      .clock(clock), .reset(reset), .start_i(start_i), .dest_i(dest_i), .base_i(base_i),
      .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .mem_en_o(mem_en_o),
      .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .data_o(data_o), .tx(tx),
      .credit_i(credit_i), .clock_tx(clock_tx)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] dest;
      logic [31:0] base;
      logic [15:0] len;
      logic [7:0]  cpat;
      int          cplen;
      int          ign_k;
      bit          consec;
   } vec_t;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0;
   logic [31:0] xfers[$];
   int          xfer_cyc[$];
   logic [31:0] reads[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        rd_pend = 1'b0;
   logic [31:0] rd_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      cyc++;
      if (!reset) begin
         if (prev_stall) begin
            check("hold_tx", 32'(tx), 32'd1);
            check("hold_data", data_o, prev_data);
         end
         if (tx && credit_i) begin
            xfers.push_back(data_o);
            xfer_cyc.push_back(cyc);
         end
         if (mem_en_o) reads.push_back(mem_addr_o);
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = tx && !credit_i;
         prev_data  = data_o;
      end else begin
         prev_stall = 1'b0;
      end
      rd_pend = mem_en_o;
      rd_addr = mem_addr_o;
   end

   always @(posedge clock) mem_data_i <= rd_pend ? mem_word(rd_addr) : 32'h0;

   task automatic clear_logs();
      xfers.delete();
      xfer_cyc.delete();
      reads.delete();
      done_cnt = 0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] exp[$];
      logic [31:0] x;
      bit          timeout;
      x = '0;
      exp.push_back({16'h0000, v.dest});
`ifdef HERMES_INJECTOR_CHECKSUM_EN
      exp.push_back(32'(v.len) + 32'd1);
`else
      exp.push_back(32'(v.len));
`endif
      for (int i = 0; i < int'(v.len); i++) begin
         exp.push_back(mem_word(v.base + 32'(i)));
         x = x ^ mem_word(v.base + 32'(i));
      end
`ifdef HERMES_INJECTOR_CHECKSUM_EN
      exp.push_back(x);
`endif
      clear_logs();
      @(posedge clock); #1;
      start_i = 1'b1; dest_i = v.dest; base_i = v.base; len_i = v.len; credit_i = 1'b1;
      timeout = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clock); #1;
         start_i = 1'b0;
         if (done_cnt != 0) begin
            timeout = 1'b0;
            break;
         end
         if (k == 1) check("busy_after_start", 32'(busy_o), 32'd1);
         credit_i = v.cpat[(k-1) % v.cplen];
         if (k == v.ign_k) begin
            start_i = 1'b1; dest_i = 16'hBAD0; base_i = 32'h0; len_i = 16'd7;
         end
      end
      check("done_timeout", 32'(timeout), 32'd0);
      credit_i = 1'b1;
      check("done_one_cycle", 32'(done_o), 32'd0);
      check("busy_after_done", 32'(busy_o), 32'd0);
      repeat (8) @(posedge clock);
      #1;
      check("done_count", 32'(done_cnt), 32'd1);
      check("flit_count", 32'(xfers.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < xfers.size(); i++)
         check($sformatf("flit[%0d] dest=%0h", i, v.dest), xfers[i], exp[i]);
      check("read_count", 32'(reads.size()), 32'(v.len));
      for (int i = 0; i < reads.size(); i++)
         check($sformatf("read_addr[%0d]", i), reads[i], v.base + 32'(i));
      if (xfer_cyc.size() > 0)
         check("done_after_last", 32'(done_cyc), 32'(xfer_cyc[xfer_cyc.size()-1] + 1));
      if (v.consec)
         for (int i = 1; i < xfer_cyc.size(); i++)
            check($sformatf("consec[%0d]", i), 32'(xfer_cyc[i]), 32'(xfer_cyc[i-1] + 1));
   endtask

   vec_t vecs[6];
   vec_t vrst;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit to;
      reset = 1'b1; start_i = 1'b0; credit_i = 1'b0;
      dest_i = '0; base_i = '0; len_i = '0;
      vecs[0] = '{dest:16'h0203, base:32'h00000010, len:16'd3, cpat:8'b1,    cplen:1, ign_k:0, consec:1'b1};
      vecs[1] = '{dest:16'h0101, base:32'h00000040, len:16'd0, cpat:8'b1,    cplen:1, ign_k:0, consec:1'b1};
      vecs[2] = '{dest:16'h0304, base:32'h00000020, len:16'd4, cpat:8'b001,  cplen:3, ign_k:0, consec:1'b0};
      vecs[3] = '{dest:16'h0000, base:32'hFFFFFFFF, len:16'd2, cpat:8'b1,    cplen:1, ign_k:0, consec:1'b1};
      vecs[4] = '{dest:16'h0707, base:32'h00000300, len:16'd3, cpat:8'b01,   cplen:2, ign_k:3, consec:1'b0};
      vecs[5] = '{dest:16'h0808, base:32'h00000400, len:16'd1, cpat:8'b1,    cplen:1, ign_k:4, consec:1'b1};
      vrst    = '{dest:16'h0606, base:32'h00000200, len:16'd2, cpat:8'b1011, cplen:4, ign_k:0, consec:1'b0};

      #12;
      check("rst_tx", 32'(tx), 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_mem_en", 32'(mem_en_o), 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      clear_logs();
      @(posedge clock); #1;
      start_i = 1'b1; dest_i = 16'h0505; base_i = 32'h100; len_i = 16'd5; credit_i = 1'b1;
      to = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clock); #1;
         start_i = 1'b0;
         if (xfers.size() >= 4) begin
            to = 1'b0;
            break;
         end
      end
      check("midpkt_timeout", 32'(to), 32'd0);
      reset = 1'b1;
      #1;
      check("midpkt_rst_tx", 32'(tx), 32'd0);
      check("midpkt_rst_busy", 32'(busy_o), 32'd0);
      check("midpkt_rst_mem_en", 32'(mem_en_o), 32'd0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      run_vec(vrst);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hermes_local_injector.md
Name: hermes_local_injector

Overview:
- Packet transmitter for a Hermes router LOCAL input port. It is the sending end of the credit-based flit link: data_o, tx, credit_i, clock_tx.
- On a start command it emits a header flit, then a size flit, then the payload flits, which it streams from a word-addressed local memory.
- One instance sits beside each PE's router. The mesh wires each injector's outputs to that router's LOCAL data_i/rx/clock_rx, and the router's credit_o to credit_i.

Parameters:
- FLIT_WIDTH, 32, flit width in bits
- MEMORY_BUS_WIDTH, 32, memory data width; must equal FLIT_WIDTH
- ADDR_WIDTH, 32, memory word-address width
- SIZE_WIDTH, 16, width of the payload length field (maximum 65535 flits)
- PREFETCH_DEPTH, 2, payload prefetch FIFO depth; power of two, 2 or more

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle launch request
- dest_i  in  16  target router {x[15:8], y[7:0]}
- base_i  in  ADDR_WIDTH  first payload word address
- len_i  in  SIZE_WIDTH  payload flit count; 0 is legal
- busy_o  out  1  high from accepted start to last flit transferred
- done_o  out  1  one-cycle pulse after the last flit transfers
- mem_en_o  out  1  memory read strobe
- mem_addr_o  out  ADDR_WIDTH  memory read address
- mem_data_i  in  MEMORY_BUS_WIDTH  read data, valid exactly 1 cycle after mem_en_o
- data_o  out  FLIT_WIDTH  flit to the router
- tx  out  1  flit valid
- credit_i  in  1  router has buffer space
- clock_tx  out  1  link clock; equals clock, combinational

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset values: tx=0, data_o=0, busy_o=0, done_o=0, mem_en_o=0, mem_addr_o=0. FIFO is emptied and state goes to IDLE.
- Transfer rule: a flit transfers on a rising edge where tx=1 and credit_i=1.
  - While tx=1 and credit_i=0, data_o and tx hold stable.
  - tx never drops without a transfer.
- State machine: IDLE -> HEADER -> SIZE -> PAYLOAD -> (TRAILER) -> DONE -> IDLE.
- IDLE:
  - start_i=1 latches dest_i, base_i and len_i, sets busy_o=1 and moves to HEADER in the next cycle.
  - start_i while busy_o=1 is ignored.
- HEADER:
  - tx=1, data_o = zero-extended dest_i.
  - Advances to SIZE on transfer.
- SIZE:
  - tx=1, data_o = zero-extended flit count. The count is len, or len+1 under the optional feature.
  - On transfer, goes to PAYLOAD if len>0, otherwise to TRAILER or DONE.
- PAYLOAD:
  - tx=1 only while the FIFO is non-empty; data_o = FIFO head.
  - Each transfer pops the FIFO and decrements the remaining count.
  - After the last payload transfer, goes to TRAILER or DONE.
- DONE:
  - Lasts one cycle: done_o=1, busy_o drops to 0, next state is IDLE.
  - A start_i in that cycle is ignored.
- Prefetch:
  - Reads start in HEADER and continue while (FIFO occupancy + reads in flight) < PREFETCH_DEPTH and reads issued < len.
  - mem_addr_o = base + issued count. Addresses wrap modulo 2^ADDR_WIDTH.
  - No read is ever issued beyond len words.
- Throughput: once the FIFO is primed and credit_i stays high, payload streams at 1 flit per cycle.
- Bubbles: an empty FIFO in PAYLOAD gives tx=0 for that cycle. This is legal.
- Simultaneous events: a FIFO push and pop in the same cycle keep occupancy unchanged.
- Reset mid-packet: the link is abandoned and tx drops asynchronously. In-flight read data arriving after reset is discarded.

Optional Feature:
- Macro: HERMES_INJECTOR_CHECKSUM_EN.
- Defined:
  - The size flit carries len+1.
  - A TRAILER state follows PAYLOAD and sends one flit equal to the XOR of all payload flits, under the same transfer rule.
  - With len=0 the trailer is 0.
- Undefined:
  - No TRAILER state and no XOR register.
  - The size flit carries len, and PAYLOAD goes straight to DONE.

Test Plan:
- dest=0x0203, base=0x10, len=3, memory[0x10..0x12]=A,B,C, credit_i held 1 -> flits 0x00000203, 3, A, B, C on consecutive transfer cycles, then done_o pulses once. With the checksum macro: size flit is 4, and a trailer A^B^C follows C.
- len=0, dest=0x0101 -> header then size 0, no mem_en_o pulses, done_o pulses 1 cycle after the size transfer.
- len=4 with credit_i toggling 1,0,0,1,... -> data_o and tx hold stable during every credit_i=0 cycle, and exactly 6 transfers occur in order.
- base=0xFFFFFFFF, len=2 -> reads at 0xFFFFFFFF then 0x00000000, with no third read.
- Reset asserted mid-payload (after 2 of 5 flits) -> tx=0 and busy_o=0 immediately. A new start afterwards sends a clean packet with the correct header.
- start_i pulsed while busy_o=1 with different dest -> ignored; the current packet completes unchanged and no second packet follows.
